// File: rtl/eth_rx_frame_ctrl_if.sv
// Signal bundle for the RMII receive frame sequencer: the RMII pin side,
// the FCS checker input handshake and the byte/status side toward the
// packet consumer.
interface eth_rx_frame_ctrl_if;
  // RMII pins
  logic        crsdv;
  logic [1:0]  rxd;
  // FCS checker handshake
  logic        chk_axiiv;
  logic [1:0]  chk_axiid;
  logic        chk_done;
  logic        chk_kill;
  // Byte stream and per-frame status
  logic        axiov;
  logic [7:0]  axiod;
  logic        frame_valid;
  logic        frame_ok;
  logic [3:0]  frame_err;
  logic [10:0] frame_len;
  logic [15:0] good_cnt;
  logic [15:0] bad_cnt;
  // Current sequencer state, for debug visibility
  logic [2:0]  fsm_state;

  // Handshake semantics: chk_axiiv qualifies chk_axiid on every cycle it is
  // high; there is no ready, so the checker must accept every beat. chk_done
  // is a level the checker holds once its verdict is known, and chk_kill is
  // only meaningful while chk_done=1. axiov and frame_valid are one-cycle
  // strobes with no backpressure; frame_ok/frame_err/frame_len are qualified
  // by frame_valid and hold until the next frame report.

  modport slave (
    input  crsdv, rxd, chk_done, chk_kill,
    output chk_axiiv, chk_axiid, axiov, axiod, frame_valid, frame_ok,
           frame_err, frame_len, good_cnt, bad_cnt, fsm_state
  );

  modport master (
    output crsdv, rxd, chk_done, chk_kill,
    input  chk_axiiv, chk_axiid, axiov, axiod, frame_valid, frame_ok,
           frame_err, frame_len, good_cnt, bad_cnt, fsm_state
  );
endinterface

// File: rtl/eth_rx_frame_ctrl.sv
// RMII receive frame sequencer. Hunts for preamble + SFD, forwards post-SFD
// dibits to the FCS checker, assembles LSB-first bytes, and at end of carrier
// combines the checker verdict with length/alignment checks into one status
// pulse plus saturating good/bad frame counters.
module eth_rx_frame_ctrl #(
  parameter int MIN_PRE     = 16,
  parameter int MIN_LEN     = 64,
  parameter int MAX_LEN     = 1518,
  parameter int CHK_TIMEOUT = 16
) (
  input logic                clk,
  input logic                rst,
  eth_rx_frame_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PRE      = 3'd1,
    S_DROP     = 3'd2,
    S_DATA     = 3'd3,
    S_WAIT_CHK = 3'd4,
    S_REPORT   = 3'd5
  } state_t;

  localparam logic [7:0]  PRE_MIN  = 8'(MIN_PRE);
  localparam logic [10:0] LEN_MIN  = 11'(MIN_LEN);
  localparam logic [10:0] LEN_MAX  = 11'(MAX_LEN);
  localparam logic [7:0]  WAIT_END = 8'(CHK_TIMEOUT - 1);

  state_t      state;
  // Only set once carrier has been seen low, so a frame already in flight
  // when reset releases (or when a report finishes) is never picked up.
  logic        armed;
  logic [7:0]  pre_cnt;
  logic [10:0] byte_cnt;
  logic [1:0]  phase;
  logic [5:0]  low_bits;   // first three dibits of the byte being assembled
  logic [7:0]  wait_cnt;
  logic        timeout_err;
  logic        align_err;
  logic        fcs_err;

  logic        chk_axiiv_q;
  logic [1:0]  chk_axiid_q;
  logic        axiov_q;
  logic [7:0]  axiod_q;
  logic        frame_valid_q;
  logic        frame_ok_q;
  logic [3:0]  frame_err_q;
  logic [10:0] frame_len_q;
  logic [15:0] good_cnt_q;
  logic [15:0] bad_cnt_q;

  logic        length_err;
  logic [3:0]  report_err;

  // Verdict for the frame currently held in the byte/error registers.
  always_comb begin
    length_err = (byte_cnt < LEN_MIN) || (byte_cnt > LEN_MAX);
    report_err = {timeout_err, align_err, length_err, fcs_err};
  end

  // Frame sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      armed         <= 1'b0;
      pre_cnt       <= '0;
      byte_cnt      <= '0;
      phase         <= '0;
      low_bits      <= '0;
      wait_cnt      <= '0;
      timeout_err   <= 1'b0;
      align_err     <= 1'b0;
      fcs_err       <= 1'b0;
      chk_axiiv_q   <= 1'b0;
      chk_axiid_q   <= '0;
      axiov_q       <= 1'b0;
      axiod_q       <= '0;
      frame_valid_q <= 1'b0;
      frame_ok_q    <= 1'b0;
      frame_err_q   <= '0;
      frame_len_q   <= '0;
      good_cnt_q    <= '0;
      bad_cnt_q     <= '0;
    end else begin
      // Strobes default low; the states below raise them for one cycle.
      chk_axiiv_q   <= 1'b0;
      axiov_q       <= 1'b0;
      frame_valid_q <= 1'b0;

      case (state)
        S_IDLE: begin
          if (!bus.crsdv) begin
            armed <= 1'b1;
          end else if (armed && bus.rxd == 2'b01) begin
            state   <= S_PRE;
            pre_cnt <= 8'd1;
          end
        end

        S_PRE: begin
          if (!bus.crsdv) begin
            state <= S_IDLE;
          end else if (bus.rxd == 2'b01) begin
            if (pre_cnt != 8'hFF) pre_cnt <= pre_cnt + 8'd1;
          end else if (bus.rxd == 2'b11 && pre_cnt >= PRE_MIN) begin
            state    <= S_DATA;
            byte_cnt <= '0;
            phase    <= '0;
            low_bits <= '0;
          end else begin
            state <= S_DROP;
          end
        end

        S_DROP: begin
          if (!bus.crsdv) state <= S_IDLE;
        end

        S_DATA: begin
          if (bus.crsdv) begin
            chk_axiiv_q <= 1'b1;
            chk_axiid_q <= bus.rxd;
            phase       <= phase + 2'd1;   // wraps to 0 after the 4th dibit
            case (phase)
              2'd0: low_bits[1:0] <= bus.rxd;
              2'd1: low_bits[3:2] <= bus.rxd;
              2'd2: low_bits[5:4] <= bus.rxd;
              default: begin
                // Bytes beyond MAX_LEN are still counted and still fed to the
                // checker, but are not presented to the consumer.
                if (byte_cnt < LEN_MAX) begin
                  axiov_q <= 1'b1;
                  axiod_q <= {bus.rxd, low_bits};
                end
                if (byte_cnt != 11'h7FF) byte_cnt <= byte_cnt + 11'd1;
              end
            endcase
          end else begin
            // End of carrier: any partial byte is simply dropped.
            state       <= S_WAIT_CHK;
            align_err   <= (phase != 2'd0);
            timeout_err <= 1'b0;
            fcs_err     <= 1'b0;
            wait_cnt    <= '0;
          end
        end

        S_WAIT_CHK: begin
          // Carrier during this wait is ignored; that frame is lost.
          if (bus.chk_done) begin
            fcs_err <= bus.chk_kill;
            state   <= S_REPORT;
          end else if (wait_cnt == WAIT_END) begin
            timeout_err <= 1'b1;
            fcs_err     <= 1'b1;
            state       <= S_REPORT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        S_REPORT: begin
          frame_valid_q <= 1'b1;
          frame_len_q   <= byte_cnt;
          frame_err_q   <= report_err;
          frame_ok_q    <= (report_err == 4'd0);
          if (report_err == 4'd0) begin
            if (good_cnt_q != 16'hFFFF) good_cnt_q <= good_cnt_q + 16'd1;
          end else begin
            if (bad_cnt_q != 16'hFFFF) bad_cnt_q <= bad_cnt_q + 16'd1;
          end
          armed <= ~bus.crsdv;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.chk_axiiv   = chk_axiiv_q;
  assign bus.chk_axiid   = chk_axiid_q;
  assign bus.axiov       = axiov_q;
  assign bus.axiod       = axiod_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_ok    = frame_ok_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.frame_len   = frame_len_q;
  assign bus.good_cnt    = good_cnt_q;
  assign bus.bad_cnt     = bad_cnt_q;
  assign bus.fsm_state   = state;

endmodule

// File: tb/tb_eth_rx_frame_ctrl.sv
// Bench for eth_rx_frame_ctrl: builds ethernet frames with real CRC32 FCS,
// drives them as RMII dibits, plays the FCS checker, and compares the byte
// stream, checker feed and per-frame status against expectations derived
// from frame length, corruption, alignment and checker behaviour.
module tb_eth_rx_frame_ctrl;
  localparam int MIN_PRE     = 16;
  localparam int MIN_LEN     = 64;
  localparam int MAX_LEN     = 1518;
  localparam int CHK_TIMEOUT = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  eth_rx_frame_ctrl_if bus();

  eth_rx_frame_ctrl #(
    .MIN_PRE(MIN_PRE), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .CHK_TIMEOUT(CHK_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];    // bytes the consumer should see
  logic [7:0] got_q[$];    // bytes seen on axiov
  logic [1:0] sent_q[$];   // post-SFD dibits driven
  logic [1:0] fed_q[$];    // dibits seen on chk_axiiv
  logic [7:0] tx[$];       // frame under construction
  int fv_pulses = 0;
  int exp_good = 0;
  int exp_bad = 0;

  // Monitor: collect outputs away from the active edge.
  always @(negedge clk) begin
    if (bus.axiov) got_q.push_back(bus.axiod);
    if (bus.chk_axiiv) fed_q.push_back(bus.chk_axiid);
    if (bus.frame_valid) fv_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc32(input logic [7:0] b[$], input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'd0, b[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Checker stand-in: verdict from the bytes actually fed to it.
  function automatic logic checker_kill();
    logic [7:0] rb[$];
    int nb;
    logic [31:0] c;
    nb = fed_q.size() / 4;
    for (int i = 0; i < nb; i++)
      rb.push_back({fed_q[4*i+3], fed_q[4*i+2], fed_q[4*i+1], fed_q[4*i]});
    if (nb < 5) return 1'b1;
    c = crc32(rb, nb - 4);
    return (c != {rb[nb-1], rb[nb-2], rb[nb-3], rb[nb-4]});
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic c, input logic [1:0] d);
    bus.crsdv = c;
    bus.rxd   = d;
    @(negedge clk);
  endtask

  task automatic send_pre(input int n01, input logic [1:0] term);
    repeat (n01) drive(1'b1, 2'b01);
    drive(1'b1, term);
  endtask

  task automatic send_bytes(input int first, input int count);
    logic [7:0] b;
    for (int i = first; i < first + count; i++) begin
      b = tx[i];
      for (int k = 0; k < 4; k++) begin
        sent_q.push_back(b[2*k +: 2]);
        drive(1'b1, b[2*k +: 2]);
      end
    end
  endtask

  // n bytes including a correct FCS; corrupt flips one payload bit afterward.
  task automatic build_frame(input int n, input bit corrupt);
    logic [31:0] c;
    int p;
    tx.delete();
    for (int i = 0; i < n - 4; i++) tx.push_back(8'($urandom_range(0, 255)));
    c = crc32(tx, n - 4);
    for (int i = 0; i < 4; i++) tx.push_back(c[8*i +: 8]);
    if (corrupt) begin
      p = $urandom_range(0, n - 5);
      tx[p] = tx[p] ^ (8'd1 << $urandom_range(0, 7));
    end
  endtask

  task automatic run_frame(input int n_pre, input int n, input bit corrupt,
                           input int n_extra, input bit no_reply);
    logic [3:0] eerr;
    int elen, d, k, bad_bytes, bad_dibits;
    bit seen;
    logic [1:0] dd;
    build_frame(n, corrupt);
    // reference expectations
    exp_q.delete();
    for (int i = 0; i < n && i < MAX_LEN; i++) exp_q.push_back(tx[i]);
    elen    = (n > 2047) ? 2047 : n;
    eerr[3] = no_reply;
    eerr[2] = (n_extra % 4) != 0;
    eerr[1] = (n < MIN_LEN) || (n > MAX_LEN);
    eerr[0] = corrupt || no_reply;
    if (eerr == 4'd0) exp_good = (exp_good == 65535) ? 65535 : exp_good + 1;
    else exp_bad = (exp_bad == 65535) ? 65535 : exp_bad + 1;

    got_q.delete(); fed_q.delete(); sent_q.delete();
    send_pre(n_pre, 2'b11);
    send_bytes(0, n);
    for (int i = 0; i < n_extra; i++) begin
      dd = 2'($urandom_range(0, 3));
      sent_q.push_back(dd);
      drive(1'b1, dd);
    end
    bus.crsdv = 1'b0;
    bus.rxd   = 2'b00;
    // k counts negedges after the edge that first samples crsdv=0 (k=1)
    d = $urandom_range(2, 10);
    seen = 1'b0;
    k = 0;
    while (!seen && k < 64) begin
      @(negedge clk);
      k++;
      if (!no_reply && k == d) begin
        bus.chk_done = 1'b1;
        bus.chk_kill = checker_kill();
      end
      if (bus.frame_valid) seen = 1'b1;
    end
    check("frame_valid_seen", 32'(seen), 32'd1);
    if (no_reply) check("timeout_latency", k - 1, CHK_TIMEOUT + 1);
    else check("report_latency", k - 1, d + 1);
    check("frame_ok", 32'(bus.frame_ok), 32'(eerr == 4'd0));
    check("frame_err", 32'(bus.frame_err), 32'(eerr));
    check("frame_len", 32'(bus.frame_len), elen);
    check("good_cnt", 32'(bus.good_cnt), exp_good);
    check("bad_cnt", 32'(bus.bad_cnt), exp_bad);
    bus.chk_done = 1'b0;
    bus.chk_kill = 1'b0;
    @(negedge clk);
    check("frame_valid_pulse", 32'(bus.frame_valid), 32'd0);
    check("frame_len_hold", 32'(bus.frame_len), elen);
    check("byte_count", got_q.size(), exp_q.size());
    bad_bytes = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) bad_bytes++;
    check("byte_data", bad_bytes, 0);
    check("fed_count", fed_q.size(), sent_q.size());
    bad_dibits = 0;
    for (int i = 0; i < fed_q.size() && i < sent_q.size(); i++)
      if (fed_q[i] !== sent_q[i]) bad_dibits++;
    check("fed_data", bad_dibits, 0);
    repeat (3) drive(1'b0, 2'b00);
  endtask

  task automatic run_drop(input int n01, input logic [1:0] term);
    int fv0;
    fv0 = fv_pulses;
    got_q.delete(); fed_q.delete(); sent_q.delete();
    send_pre(n01, term);
    build_frame(16, 1'b0);
    send_bytes(0, 16);
    bus.crsdv = 1'b0;
    bus.rxd   = 2'b00;
    repeat (CHK_TIMEOUT + 8) @(negedge clk);
    check("drop_fed", fed_q.size(), 0);
    check("drop_bytes", got_q.size(), 0);
    check("drop_frame_valid", fv_pulses - fv0, 0);
    check("drop_good", 32'(bus.good_cnt), exp_good);
    check("drop_bad", 32'(bus.bad_cnt), exp_bad);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int fv0;
    rst = 1'b1;
    bus.crsdv = 1'b0; bus.rxd = 2'b00;
    bus.chk_done = 1'b0; bus.chk_kill = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_strobes", {14'd0, bus.chk_axiiv, bus.chk_axiid, bus.axiov, bus.axiod,
                            bus.frame_valid, bus.frame_ok, bus.frame_err}, 32'd0);
    check("reset_len_state", {18'd0, bus.frame_len, bus.fsm_state}, 32'd0);
    check("reset_counters", {bus.good_cnt, bus.bad_cnt}, 32'd0);
    rst = 1'b0;
    repeat (2) drive(1'b0, 2'b00);

    run_frame(31, 64, 1'b0, 0, 1'b0);            // good frame
    run_frame(31, 64, 1'b1, 0, 1'b0);            // corrupt FCS
    run_frame(31, 20, 1'b0, 0, 1'b0);            // runt
    run_frame(31, 64, 1'b0, 2, 1'b0);            // misaligned
    run_drop(10, 2'b11);                         // short preamble
    run_drop(5, 2'b00);                          // bad terminator
    run_drop(MIN_PRE - 1, 2'b11);                // one short of minimum
    run_frame(MIN_PRE, 64, 1'b0, 0, 1'b0);       // minimum preamble
    run_frame(31, MIN_LEN - 1, 1'b0, 0, 1'b0);   // one byte too short
    run_frame(31, 64, 1'b0, 0, 1'b1);            // checker never answers
    run_frame(20, MAX_LEN, 1'b0, 0, 1'b0);       // longest legal frame
    run_frame(20, MAX_LEN + 2, 1'b0, 1, 1'b0);   // oversize and misaligned
    for (int r = 0; r < 6; r++)
      run_frame($urandom_range(MIN_PRE, 40), $urandom_range(40, 200),
                1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0);

    // Reset during byte 30 with carrier held; the rest of the carrier burst
    // contains a full preamble + SFD that must not be locked onto.
    build_frame(100, 1'b0);
    send_pre(24, 2'b11);
    send_bytes(0, 29);
    drive(1'b1, tx[29][1:0]);
    drive(1'b1, tx[29][3:2]);
    rst = 1'b1;
    drive(1'b1, 2'b01);
    rst = 1'b0;
    check("midrst_strobes", {14'd0, bus.chk_axiiv, bus.chk_axiid, bus.axiov, bus.axiod,
                             bus.frame_valid, bus.frame_ok, bus.frame_err}, 32'd0);
    check("midrst_len", 32'(bus.frame_len), 32'd0);
    check("midrst_counters", {bus.good_cnt, bus.bad_cnt}, 32'd0);
    exp_good = 0;
    exp_bad = 0;
    got_q.delete(); fed_q.delete();
    fv0 = fv_pulses;
    send_pre(40, 2'b11);
    send_bytes(30, 40);
    bus.crsdv = 1'b0;
    bus.rxd   = 2'b00;
    repeat (CHK_TIMEOUT + 8) @(negedge clk);
    check("midrst_fed", fed_q.size(), 0);
    check("midrst_bytes", got_q.size(), 0);
    check("midrst_frame_valid", fv_pulses - fv0, 0);
    run_frame(31, 64, 1'b0, 0, 1'b0);            // good_cnt should read 1

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
